// File: rtl/mem_responder_if.sv
// Split read/write request channels and their tagged return channels.
// The master drives requests; the slave (memory responder) drives returns.
interface mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_address;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ret_ack;
    logic [ADDR_W-1:0] wr_ret_address;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_address;
    logic              rd_ret_ack;
    logic [ADDR_W-1:0] rd_ret_address;
    logic [DATA_W-1:0] rd_ret_data;

    modport master (
        output wr_en, wr_address, wr_data, rd_en, rd_address,
        input  wr_ret_ack, wr_ret_address, rd_ret_ack, rd_ret_address, rd_ret_data
    );

    modport slave (
        input  wr_en, wr_address, wr_data, rd_en, rd_address,
        output wr_ret_ack, wr_ret_address, rd_ret_ack, rd_ret_address, rd_ret_data
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory endpoint with fixed-latency, address-tagged write acks
// and read returns; one write and one read accepted every cycle.
module mem_responder #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    logic [LATENCY-1:0] r_wr_vld;
    logic [ADDR_W-1:0]  r_wr_addr [LATENCY];
    logic [LATENCY-1:0] r_rd_vld;
    logic [ADDR_W-1:0]  r_rd_addr [LATENCY];
    logic [DATA_W-1:0]  r_rd_data [LATENCY];

    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [DATA_W-1:0] w_rd_word;

    assign w_wr_idx = bus.wr_address[IDX_W-1:0];
    assign w_rd_idx = bus.rd_address[IDX_W-1:0];

    // Write-first: a same-cycle write to the read index bypasses the array.
    assign w_rd_word = (bus.wr_en && (w_wr_idx == w_rd_idx)) ? bus.wr_data : r_mem[w_rd_idx];

    // Storage is deliberately outside the reset domain so commits survive reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            r_mem[w_wr_idx] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_vld[0]  <= 1'b0;
            r_wr_addr[0] <= '0;
            r_rd_vld[0]  <= 1'b0;
            r_rd_addr[0] <= '0;
            r_rd_data[0] <= '0;
        end else begin
            r_wr_vld[0]  <= bus.wr_en;
            r_wr_addr[0] <= bus.wr_en ? bus.wr_address : '0;
            r_rd_vld[0]  <= bus.rd_en;
            r_rd_addr[0] <= bus.rd_en ? bus.rd_address : '0;
            r_rd_data[0] <= bus.rd_en ? w_rd_word : '0;
        end
    end

    // Payload is zeroed on entry when invalid, so idle outputs read as 0.
    for (genvar g = 1; g < LATENCY; g++) begin : gen_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wr_vld[g]  <= 1'b0;
                r_wr_addr[g] <= '0;
                r_rd_vld[g]  <= 1'b0;
                r_rd_addr[g] <= '0;
                r_rd_data[g] <= '0;
            end else begin
                r_wr_vld[g]  <= r_wr_vld[g-1];
                r_wr_addr[g] <= r_wr_addr[g-1];
                r_rd_vld[g]  <= r_rd_vld[g-1];
                r_rd_addr[g] <= r_rd_addr[g-1];
                r_rd_data[g] <= r_rd_data[g-1];
            end
        end
    end

    assign bus.wr_ret_ack     = r_wr_vld[LATENCY-1];
    assign bus.wr_ret_address = r_wr_addr[LATENCY-1];
    assign bus.rd_ret_ack     = r_rd_vld[LATENCY-1];
    assign bus.rd_ret_address = r_rd_addr[LATENCY-1];
    assign bus.rd_ret_data    = r_rd_data[LATENCY-1];
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LATENCY=4 instance against a scheduled-return
// model, plus a LATENCY=1 instance for the registered-response case.
module tb_mem_responder;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int MW  = 1024;
    localparam int LAT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) b4 ();
    mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW), .LATENCY(LAT)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4)
    );
    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Model: memory contents by word index, and expected returns keyed by the
    // edge number after which they must be visible (-1 data = unknown word).
    int m_mem     [int];
    int e_wr      [int];
    int e_rd_addr [int];
    int e_rd_data [int];

    task automatic cyc(input logic we, input logic [15:0] wa, input logic [15:0] wd,
                       input logic re, input logic [15:0] ra);
        int idx;
        b4.wr_en = we; b4.wr_address = wa; b4.wr_data = wd;
        b4.rd_en = re; b4.rd_address = ra;
        @(posedge clk);
        edge_n++;
        if (rst_n) begin
            if (we) begin
                m_mem[int'(wa) % MW] = int'(wd);
                e_wr[edge_n + LAT - 1] = int'(wa);
            end
            if (re) begin
                idx = int'(ra) % MW;
                e_rd_addr[edge_n + LAT - 1] = int'(ra);
                e_rd_data[edge_n + LAT - 1] = m_mem.exists(idx) ? m_mem[idx] : -1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({b4.wr_ret_ack, b4.wr_ret_address, b4.rd_ret_ack, b4.rd_ret_address, b4.rd_ret_data} !== 51'd0) begin
            errors++;
            $display("FAIL reset_l4: outputs wa=%b/%h ra=%b/%h d=%h, expected all 0",
                     b4.wr_ret_ack, b4.wr_ret_address, b4.rd_ret_ack, b4.rd_ret_address, b4.rd_ret_data);
        end
        checks++;
        if ({b1.wr_ret_ack, b1.wr_ret_address, b1.rd_ret_ack, b1.rd_ret_address, b1.rd_ret_data} !== 51'd0) begin
            errors++;
            $display("FAIL reset_l1: outputs wa=%b/%h ra=%b/%h d=%h, expected all 0",
                     b1.wr_ret_ack, b1.wr_ret_address, b1.rd_ret_ack, b1.rd_ret_address, b1.rd_ret_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [15:0] rd_seen [$];
        int wr_cnt = 0;
        logic xk; logic [15:0] xa; logic [15:0] xd; logic dk;
        for (int n = 0; n < 24; n++) begin
            if (n < 10)      cyc(1'b1, 16'(150 + n), 16'(n), 1'b0, 16'h0);
            else if (n < 20) cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'(140 + n));
            else             cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
            xk = e_wr.exists(edge_n);
            xa = xk ? 16'(e_wr[edge_n]) : 16'h0;
            checks++;
            if (b4.wr_ret_ack !== xk || b4.wr_ret_address !== xa) begin
                errors++;
                $display("FAIL stream_wr edge %0d: ack=%b addr=%h, expected ack=%b addr=%h",
                         edge_n, b4.wr_ret_ack, b4.wr_ret_address, xk, xa);
            end
            xk = e_rd_addr.exists(edge_n);
            xa = xk ? 16'(e_rd_addr[edge_n]) : 16'h0;
            dk = !xk || (e_rd_data[edge_n] >= 0);
            xd = (xk && dk) ? 16'(e_rd_data[edge_n]) : 16'h0;
            checks++;
            if (b4.rd_ret_ack !== xk || b4.rd_ret_address !== xa || (dk && b4.rd_ret_data !== xd)) begin
                errors++;
                $display("FAIL stream_rd edge %0d: ack=%b addr=%h data=%h, expected ack=%b addr=%h data=%h",
                         edge_n, b4.rd_ret_ack, b4.rd_ret_address, b4.rd_ret_data, xk, xa, xd);
            end
            if (b4.wr_ret_ack === 1'b1) wr_cnt++;
            if (b4.rd_ret_ack === 1'b1) rd_seen.push_back(b4.rd_ret_data);
        end
        checks++;
        if (wr_cnt != 10) begin
            errors++;
            $display("FAIL stream_wr_count: got %0d acks, expected 10", wr_cnt);
        end
        checks++;
        if (rd_seen.size() != 10) begin
            errors++;
            $display("FAIL stream_rd_count: got %0d returns, expected 10", rd_seen.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (rd_seen[i] !== 16'(i)) begin
                    errors++;
                    $display("FAIL stream_rd_order[%0d]: got %h, expected %h", i, rd_seen[i], 16'(i));
                end
            end
        end
    endtask

    task automatic test_collision();
        cyc(1'b1, 16'h0020, 16'hBEEF, 1'b1, 16'h0020);
        repeat (3) cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        checks++;
        if (b4.rd_ret_ack !== 1'b1 || b4.rd_ret_address !== 16'h0020 || b4.rd_ret_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL collision_rd: ack=%b addr=%h data=%h, expected ack=1 addr=0020 data=beef",
                     b4.rd_ret_ack, b4.rd_ret_address, b4.rd_ret_data);
        end
        checks++;
        if (b4.wr_ret_ack !== 1'b1 || b4.wr_ret_address !== 16'h0020) begin
            errors++;
            $display("FAIL collision_wr: ack=%b addr=%h, expected ack=1 addr=0020",
                     b4.wr_ret_ack, b4.wr_ret_address);
        end
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic test_alias();
        cyc(1'b1, 16'h0005, 16'h1234, 1'b0, 16'h0);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0405);
        repeat (3) cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        checks++;
        if (b4.rd_ret_ack !== 1'b1 || b4.rd_ret_address !== 16'h0405 || b4.rd_ret_data !== 16'h1234) begin
            errors++;
            $display("FAIL alias_rd: ack=%b addr=%h data=%h, expected ack=1 addr=0405 data=1234",
                     b4.rd_ret_ack, b4.rd_ret_address, b4.rd_ret_data);
        end
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic test_random();
        logic xk; logic [15:0] xa; logic [15:0] xd; logic dk;
        logic we, re; logic [15:0] wa, wd, ra;
        for (int n = 0; n < 300; n++) begin
            we = (n < 290) && ($urandom_range(0, 9) < 7);
            re = (n < 290) && ($urandom_range(0, 9) < 7);
            wa = 16'((($urandom & 32'h3F) << 10) | $urandom_range(0, 31));
            ra = 16'((($urandom & 32'h3F) << 10) | $urandom_range(0, 31));
            wd = 16'($urandom);
            cyc(we, wa, wd, re, ra);
            xk = e_wr.exists(edge_n);
            xa = xk ? 16'(e_wr[edge_n]) : 16'h0;
            checks++;
            if (b4.wr_ret_ack !== xk || b4.wr_ret_address !== xa) begin
                errors++;
                $display("FAIL random_wr edge %0d: ack=%b addr=%h, expected ack=%b addr=%h",
                         edge_n, b4.wr_ret_ack, b4.wr_ret_address, xk, xa);
            end
            xk = e_rd_addr.exists(edge_n);
            xa = xk ? 16'(e_rd_addr[edge_n]) : 16'h0;
            dk = !xk || (e_rd_data[edge_n] >= 0);
            xd = (xk && dk) ? 16'(e_rd_data[edge_n]) : 16'h0;
            checks++;
            if (b4.rd_ret_ack !== xk || b4.rd_ret_address !== xa || (dk && b4.rd_ret_data !== xd)) begin
                errors++;
                $display("FAIL random_rd edge %0d: ack=%b addr=%h data=%h, expected ack=%b addr=%h data=%h",
                         edge_n, b4.rd_ret_ack, b4.rd_ret_address, b4.rd_ret_data, xk, xa, xd);
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 16'(16'h0300 + i), 16'(16'h5A00 + i), 1'b1, 16'(16'h0300 + i));
        rst_n = 1'b0;
        e_wr.delete(); e_rd_addr.delete(); e_rd_data.delete();
        for (int n = 0; n < 8; n++) begin
            if (n == 0) #1;
            else        cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
            if (n == 2) rst_n = 1'b1;
            checks++;
            if ({b4.wr_ret_ack, b4.wr_ret_address, b4.rd_ret_ack, b4.rd_ret_address, b4.rd_ret_data} !== 51'd0) begin
                errors++;
                $display("FAIL midflight_drop step %0d: wa=%b/%h ra=%b/%h d=%h, expected all 0", n,
                         b4.wr_ret_ack, b4.wr_ret_address, b4.rd_ret_ack, b4.rd_ret_address, b4.rd_ret_data);
            end
        end
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0301);
        repeat (3) cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        checks++;
        if (b4.rd_ret_ack !== 1'b1 || b4.rd_ret_address !== 16'h0301 || b4.rd_ret_data !== 16'h5A01) begin
            errors++;
            $display("FAIL midflight_commit: ack=%b addr=%h data=%h, expected ack=1 addr=0301 data=5a01",
                     b4.rd_ret_ack, b4.rd_ret_address, b4.rd_ret_data);
        end
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic test_latency1();
        b1.wr_en = 1'b1; b1.wr_address = 16'h0007; b1.wr_data = 16'h00AA;
        @(posedge clk); #1;
        b1.wr_en = 1'b0; b1.wr_address = 16'h0; b1.wr_data = 16'h0;
        checks++;
        if (b1.wr_ret_ack !== 1'b1 || b1.wr_ret_address !== 16'h0007 || b1.rd_ret_ack !== 1'b0 ||
            b1.rd_ret_address !== 16'h0 || b1.rd_ret_data !== 16'h0) begin
            errors++;
            $display("FAIL lat1_wr: wa=%b/%h ra=%b/%h d=%h, expected wa=1/0007 ra=0/0000 d=0000",
                     b1.wr_ret_ack, b1.wr_ret_address, b1.rd_ret_ack, b1.rd_ret_address, b1.rd_ret_data);
        end
        b1.rd_en = 1'b1; b1.rd_address = 16'h0007;
        @(posedge clk); #1;
        b1.rd_en = 1'b0; b1.rd_address = 16'h0;
        checks++;
        if (b1.rd_ret_ack !== 1'b1 || b1.rd_ret_address !== 16'h0007 || b1.rd_ret_data !== 16'h00AA ||
            b1.wr_ret_ack !== 1'b0 || b1.wr_ret_address !== 16'h0) begin
            errors++;
            $display("FAIL lat1_rd: wa=%b/%h ra=%b/%h d=%h, expected wa=0/0000 ra=1/0007 d=00aa",
                     b1.wr_ret_ack, b1.wr_ret_address, b1.rd_ret_ack, b1.rd_ret_address, b1.rd_ret_data);
        end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            checks++;
            if ({b1.wr_ret_ack, b1.wr_ret_address, b1.rd_ret_ack, b1.rd_ret_address, b1.rd_ret_data} !== 51'd0) begin
                errors++;
                $display("FAIL lat1_idle %0d: wa=%b/%h ra=%b/%h d=%h, expected all 0", n,
                         b1.wr_ret_ack, b1.wr_ret_address, b1.rd_ret_ack, b1.rd_ret_address, b1.rd_ret_data);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        b4.wr_en = 1'b0; b4.wr_address = '0; b4.wr_data = '0; b4.rd_en = 1'b0; b4.rd_address = '0;
        b1.wr_en = 1'b0; b1.wr_address = '0; b1.wr_data = '0; b1.rd_en = 1'b0; b1.rd_address = '0;
        test_reset();
        test_stream();
        test_collision();
        test_alias();
        test_random();
        test_reset_midflight();
        test_latency1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
